// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency memory between the fetch (IF) and
//            load/store (DM) ports using req/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [2:0]        dm_func,
    input  logic [31:0]       dm_wdata,
    output logic              dm_ready,
    output logic [31:0]       dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_func,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              grant_dm
);

    localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STREAK_W = $clog2(MAX_STREAK + 1);

    localparam logic [CNT_W-1:0]    CNT_INIT   = CNT_W'(MEM_LAT - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
    localparam logic [2:0]          FUNC_WORD  = 3'b010;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]          state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                mem_en_q,    mem_en_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [2:0]          mem_func_q,  mem_func_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                grant_dm_q,  grant_dm_d;
    logic                if_ready_q,  if_ready_d;
    logic                dm_ready_q,  dm_ready_d;
    logic [31:0]         if_rdata_q,  if_rdata_d;
    logic [31:0]         dm_rdata_q,  dm_rdata_d;

    // IF only wins a contested cycle once DM has used up its streak allowance
    logic pick_if;
    assign pick_if = if_req && (!dm_req || (streak_q == STREAK_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_func_q  <= '0;
            mem_wdata_q <= '0;
            grant_dm_q  <= 1'b0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_func_q  <= mem_func_d;
            mem_wdata_q <= mem_wdata_d;
            grant_dm_q  <= grant_dm_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (if_req || dm_req) state_d = S_ACCESS;
            S_ACCESS: if (cnt_q == '0)      state_d = S_RESP;
            S_RESP:                         state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_func_d  = mem_func_q;
        mem_wdata_d = mem_wdata_q;
        grant_dm_d  = grant_dm_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    cnt_d    = CNT_INIT;
                    mem_en_d = 1'b1;
                    if (pick_if) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_func_d  = FUNC_WORD;
                        mem_wdata_d = '0;
                        grant_dm_d  = 1'b0;
                        streak_d    = '0;
                    end else begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_func_d  = dm_func;
                        mem_wdata_d = dm_wdata;
                        grant_dm_d  = 1'b1;
                        if (!if_req)
                            streak_d = '0;
                        else if (streak_q != STREAK_MAX)
                            streak_d = streak_q + STREAK_W'(1);
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!grant_dm_q)
                        if_rdata_d = mem_rdata;
                    else if (!mem_we_q)
                        dm_rdata_d = mem_rdata;
                    if_ready_d = !grant_dm_q;
                    dm_ready_d = grant_dm_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_en    = mem_en_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_func  = mem_func_q;
        mem_wdata = mem_wdata_q;
        grant_dm  = grant_dm_q;
        if_ready  = if_ready_q;
        dm_ready  = dm_ready_q;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
        busy      = (state_q != S_IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Randomised scoreboard bench for mem_port_arbiter; a second
//            instance with single-cycle latency streams back-to-back fetches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int MAXS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;

    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [2:0]  dm_func = '0;
    logic        if_ready, dm_ready, mem_en, mem_we, busy, grant_dm;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_func;

    logic        if_ready1, dm_ready1, mem_en1, mem_we1, busy1, grant_dm1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic [2:0]  mem_func1;
    logic        one = 1'b1, zero = 1'b0;
    logic [31:0] addr1 = 32'h100, zero32 = '0;
    logic [2:0]  zero3 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fmem(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0050_0093 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_1234);
    endfunction

    assign mem_rdata  = fmem(mem_addr);
    assign mem_rdata1 = fmem(mem_addr1);

    mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(LAT), .MAX_STREAK(MAXS)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_func(dm_func),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_func(mem_func),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .grant_dm(grant_dm)
    );

    mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(1), .MAX_STREAK(MAXS)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(one), .if_addr(addr1), .if_ready(if_ready1), .if_rdata(if_rdata1),
        .dm_req(zero), .dm_we(zero), .dm_addr(zero32), .dm_func(zero3),
        .dm_wdata(zero32), .dm_ready(dm_ready1), .dm_rdata(dm_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_func(mem_func1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1), .grant_dm(grant_dm1)
    );

    int n_pass = 0, n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    typedef struct {
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [2:0]  func;
        logic [31:0] wdata;
        int          g;
    } txn_t;

    txn_t sb[$];

    // Requester agents and transaction-level arbitration model
    bit          if_pend = 0, if_gnt = 0, dm_pend = 0, dm_gnt = 0;
    bit          dm_we_a = 0, has_txn = 0, rel_dm = 0;
    logic [31:0] if_a = '0, dm_a = '0, dm_wd = '0;
    logic [2:0]  dm_f = '0;
    int          free_at = 0, rel_cyc = 0, streak = 0;
    bit          started = 0;

    task automatic model();
        txn_t t;
        bit   win_dm;
        if (cyc >= free_at && (if_pend || dm_pend)) begin
            win_dm = dm_pend && !(if_pend && streak == MAXS);
            if (win_dm) streak = if_pend ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
            else        streak = 0;
            t.dm    = win_dm;
            t.we    = win_dm ? dm_we_a : 1'b0;
            t.addr  = win_dm ? dm_a : if_a;
            t.func  = win_dm ? dm_f : 3'b010;
            t.wdata = win_dm ? dm_wd : 32'h0;
            t.g     = cyc;
            sb.push_back(t);
            free_at = cyc + LAT + 2;
            rel_cyc = cyc + LAT + 1;
            rel_dm  = win_dm;
            has_txn = 1;
            if (win_dm) dm_gnt = 1; else if_gnt = 1;
        end
    endtask

    task automatic new_dm();
        dm_we_a = 1'($urandom_range(1));
        dm_a    = $urandom;
        dm_f    = 3'($urandom_range(7));
        dm_wd   = $urandom;
    endtask

    task automatic step(input int p_if, input int p_dm);
        @(posedge clk); #1;
        if (has_txn && cyc == rel_cyc) begin
            if (rel_dm) begin dm_pend = 0; dm_gnt = 0; end
            else        begin if_pend = 0; if_gnt = 0; end
            has_txn = 0;
        end
        if (!if_pend && int'($urandom_range(99)) < p_if) begin
            if_pend = 1; if_a = {$urandom_range(32'h3FFF_FFFF), 2'b00};
        end else if (p_if > 0 && if_pend && !if_gnt && $urandom_range(7) == 0) begin
            if_a = {$urandom_range(32'h3FFF_FFFF), 2'b00};
        end
        if (!dm_pend && int'($urandom_range(99)) < p_dm) begin
            dm_pend = 1; new_dm();
        end else if (p_dm > 0 && dm_pend && !dm_gnt && $urandom_range(7) == 0) begin
            new_dm();
        end
        if_req = if_pend; if_addr = if_a;
        dm_req = dm_pend; dm_we = dm_we_a; dm_addr = dm_a; dm_func = dm_f; dm_wdata = dm_wd;
        model();
    endtask

    // Scoreboard monitor
    txn_t        hm;
    bit          has, in_acc;
    logic [31:0] exp_dm = '0;
    int          last1 = -1, n1 = 0;

    always @(negedge clk) begin
        if (rst || !started) begin
            exp_dm = '0;
            last1  = -1;
        end else begin
            has = (sb.size() > 0);
            if (has) hm = sb[0];
            in_acc = has && cyc > hm.g && cyc <= hm.g + LAT;
            chk("mem_en", {31'b0, mem_en}, {31'b0, in_acc});
            if (in_acc) begin
                chk("mem_addr", mem_addr, hm.addr);
                chk("mem_we", {31'b0, mem_we}, {31'b0, hm.we});
                chk("mem_func", {29'b0, mem_func}, {29'b0, hm.func});
                chk("mem_wdata", mem_wdata, hm.wdata);
                chk("grant_dm", {31'b0, grant_dm}, {31'b0, hm.dm});
            end
            chk("busy", {31'b0, busy}, {31'b0, has && cyc > hm.g && cyc <= hm.g + LAT + 1});
            if (if_ready || dm_ready) begin
                if (!has) begin
                    chk("ready_unexpected", {30'b0, if_ready, dm_ready}, 32'h0);
                end else begin
                    chk("ready_cycle", cyc, hm.g + LAT + 1);
                    chk("ready_port", {30'b0, if_ready, dm_ready}, hm.dm ? 32'h1 : 32'h2);
                    if (!hm.dm) begin
                        chk("if_rdata", if_rdata, fmem(hm.addr));
                    end else if (!hm.we) begin
                        exp_dm = fmem(hm.addr);
                        chk("dm_rdata_load", dm_rdata, exp_dm);
                    end else begin
                        chk("dm_rdata_store", dm_rdata, exp_dm);
                    end
                    void'(sb.pop_front());
                end
            end else if (has && cyc > hm.g + LAT) begin
                chk("ready_missing", {30'b0, if_ready, dm_ready}, hm.dm ? 32'h1 : 32'h2);
                void'(sb.pop_front());
            end
            if (if_ready1) begin
                n1++;
                chk("lat1_rdata", if_rdata1, fmem(32'h100));
                chk("lat1_dm_ready", {31'b0, dm_ready1}, 32'h0);
                if (last1 >= 0) chk("lat1_spacing", cyc - last1, 32'd3);
                last1 = cyc;
            end else if (last1 >= 0 && cyc - last1 > 3) begin
                chk("lat1_pulse_missing", {31'b0, if_ready1}, 32'h1);
                last1 = -1;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_grant_dm", {31'b0, grant_dm}, 32'h0);
        chk("rst_ready", {30'b0, if_ready, dm_ready}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        started = 1;

        // Single fetch, then contested IF/DM, then a byte store
        if_pend = 1; if_a = 32'h10;
        repeat (8) step(0, 0);
        if_pend = 1; if_a = 32'h20;
        dm_pend = 1; dm_we_a = 0; dm_a = 32'h40; dm_f = 3'b010; dm_wd = '0;
        repeat (12) step(0, 0);
        dm_pend = 1; dm_we_a = 1; dm_a = 32'h2C; dm_f = 3'b000; dm_wd = 32'hAB;
        repeat (8) step(0, 0);

        repeat (400) step(40, 60);
        repeat (150) step(100, 100);
        repeat (12) step(0, 0);

        // Reset during the first access cycle
        if_pend = 1; if_a = 32'h80;
        step(0, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort_mem_en", {31'b0, mem_en}, 32'h0);
        chk("abort_mem_we", {31'b0, mem_we}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_ready", {30'b0, if_ready, dm_ready}, 32'h0);
        sb.delete();
        has_txn = 0; if_gnt = 0; dm_gnt = 0;
        free_at = 0; streak = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        model();
        repeat (10) step(0, 0);

        repeat (300) step(50, 50);
        repeat (12) step(0, 0);
        @(negedge clk); #1;
        chk("sb_drained", sb.size(), 32'h0);
        chk("lat1_pulses_seen", {31'b0, n1 > 100}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
